// File: rtl/parallel2serial_tx.sv
// parallel2serial_tx: buffers DATA_W-bit words in a 2-entry FIFO and emits
// each word MSB-first, one bit per clock, with dout_valid framing the word.
// Optional feature macro P2S_GAP_CYCLE_EN: inserts one idle GAP cycle
// (dout_valid = 0) after the last bit of every word.
module parallel2serial_tx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din_parallel,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout_serial,
    output logic              dout_valid,
    output logic              busy
);

    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef P2S_GAP_CYCLE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;
`else
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;
`endif

    state_t              r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_dout_serial;
    logic                r_dout_valid;

    logic [DATA_W-1:0]   r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [FCNT_W-1:0]   r_count;

    logic                w_ready;
    logic                w_nonempty;
    logic                w_push;
    logic                w_pop;
    logic                w_last_bit;
    logic [DATA_W-1:0]   w_head;

    // Handshake and FIFO status, decoded from registered state only
    assign w_ready    = (r_count != FCNT_W'(FIFO_DEPTH));
    assign w_nonempty = (r_count != '0);
    assign w_push     = din_valid && w_ready;
    assign w_last_bit = (r_bit_cnt == '0);
    assign w_head     = r_mem[r_rd_ptr];

    // Pop request: load a new word whenever the shifter is free
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = w_nonempty;
`ifdef P2S_GAP_CYCLE_EN
            S_SHIFT: w_pop = 1'b0;
            S_GAP:   w_pop = w_nonempty;
`else
            S_SHIFT: w_pop = w_last_bit && w_nonempty;
`endif
            default: w_pop = 1'b0;
        endcase
    end

    // Two-entry FIFO: storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din_parallel;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer FSM with registered serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_dout_serial <= 1'b0;
            r_dout_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state       <= S_SHIFT;
                        r_shift       <= w_head;
                        r_bit_cnt     <= CNT_W'(DATA_W - 1);
                        r_dout_serial <= w_head[DATA_W-1];
                        r_dout_valid  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!w_last_bit) begin
                        r_shift       <= {r_shift[DATA_W-2:0], 1'b0};
                        r_bit_cnt     <= r_bit_cnt - CNT_W'(1);
                        r_dout_serial <= r_shift[DATA_W-2];
                        r_dout_valid  <= 1'b1;
`ifdef P2S_GAP_CYCLE_EN
                    end else begin
                        r_state       <= S_GAP;
                        r_shift       <= '0;
                        r_dout_serial <= 1'b0;
                        r_dout_valid  <= 1'b0;
                    end
`else
                    end else if (w_pop) begin
                        // Reload on the last bit so words run back-to-back
                        r_shift       <= w_head;
                        r_bit_cnt     <= CNT_W'(DATA_W - 1);
                        r_dout_serial <= w_head[DATA_W-1];
                        r_dout_valid  <= 1'b1;
                    end else begin
                        r_state       <= S_IDLE;
                        r_shift       <= '0;
                        r_dout_serial <= 1'b0;
                        r_dout_valid  <= 1'b0;
                    end
`endif
                end
`ifdef P2S_GAP_CYCLE_EN
                S_GAP: begin
                    if (w_pop) begin
                        r_state       <= S_SHIFT;
                        r_shift       <= w_head;
                        r_bit_cnt     <= CNT_W'(DATA_W - 1);
                        r_dout_serial <= w_head[DATA_W-1];
                        r_dout_valid  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_state       <= S_IDLE;
                    r_dout_serial <= 1'b0;
                    r_dout_valid  <= 1'b0;
                end
            endcase
        end
    end

    // Output drive
    assign din_ready   = w_ready;
    assign dout_serial = r_dout_serial;
    assign dout_valid  = r_dout_valid;
    assign busy        = (r_state == S_SHIFT) || w_nonempty;

endmodule

// File: tb/tb_parallel2serial_tx.sv
// tb_parallel2serial_tx: randomized scoreboard bench for parallel2serial_tx.
// Accepted words are queued; a negedge monitor predicts the serial stream
// from the framing rules and compares every output each cycle.
`timescale 1ns/1ps
module tb_parallel2serial_tx;

    localparam int unsigned DATA_W    = 8;
    localparam int          MAX_PRINT = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] din_parallel = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic              dout_serial;
    logic              dout_valid;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int sent     = 0;
    int words_out = 0;

    // Reference model state (owned by the monitor)
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] cur_word = '0;
    bit                m_active = 1'b0;
    int                m_pos = 0;
    bit                pend = 1'b0;
    logic [DATA_W-1:0] pend_data = '0;
    bit                may_pop;

    parallel2serial_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_parallel(din_parallel),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dout_serial (dout_serial),
        .dout_valid  (dout_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= MAX_PRINT)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: advance the model one edge, then compare every output
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            pend     = 1'b0;
            check("rst_dout_valid",  32'(dout_valid),  32'd0);
            check("rst_dout_serial", 32'(dout_serial), 32'd0);
            check("rst_din_ready",   32'(din_ready),   32'd1);
            check("rst_busy",        32'(busy),        32'd0);
        end else begin
            if (m_active && m_pos != DATA_W - 1) begin
                m_pos++;
            end else begin
                if (m_active) words_out++;
`ifdef P2S_GAP_CYCLE_EN
                may_pop = !m_active;
`else
                may_pop = 1'b1;
`endif
                if (may_pop && exp_q.size() != 0) begin
                    cur_word = exp_q.pop_front();
                    m_active = 1'b1;
                    m_pos    = 0;
                end else begin
                    m_active = 1'b0;
                    m_pos    = 0;
                end
            end
            if (pend) exp_q.push_back(pend_data);

            check("dout_valid", 32'(dout_valid), 32'(m_active));
            if (m_active)
                check("dout_serial", 32'(dout_serial), 32'(cur_word[DATA_W-1-m_pos]));
            else
                check("dout_serial_idle", 32'(dout_serial), 32'd0);
            check("din_ready", 32'(din_ready), 32'(exp_q.size() != 2));
            check("busy", 32'(busy), 32'(m_active || exp_q.size() != 0));

            pend      = din_valid && (exp_q.size() != 2);
            pend_data = din_parallel;
        end
    end

    // Drive one word and hold it until the DUT accepts it
    task automatic send(input logic [DATA_W-1:0] w);
        int guard;
        bit acc;
        guard = 0;
        acc = 1'b0;
        din_parallel = w;
        din_valid    = 1'b1;
        do begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        check("send_accept", 32'(acc), 32'd1);
        if (acc) sent++;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid();
        int guard;
        guard = 0;
        while (!dout_valid && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("wait_valid", 32'(dout_valid), 32'd1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        din_valid = 1'b0;
        while ((busy || dout_valid) && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_idle", 32'(busy), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_din_ready",  32'(din_ready),  32'd1);
        check("reset_dout_valid", 32'(dout_valid), 32'd0);
        check("reset_busy",       32'(busy),       32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word
        send(8'hA5);
        drain();

        // Back-to-back words
        send(8'h3C);
        send(8'hFF);
        send(8'h01);
        drain();

        // FIFO full hold with a repeated pattern
        repeat (6) send(8'h55);
        drain();

        // Gap / contiguity pair
        send(8'hAA);
        send(8'h55);
        drain();

        // Push on the same edge as a reload with one word buffered
        send(8'h11);
        send(8'h22);
        din_valid = 1'b0;
        wait_valid();
        repeat (DATA_W - 1) begin
            @(posedge clk);
            #1;
        end
        din_parallel = 8'h0F;
        din_valid    = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sent++;
`ifdef P2S_GAP_CYCLE_EN
        check("pushpop_ready", 32'(din_ready), 32'd0);
`else
        check("pushpop_ready", 32'(din_ready), 32'd1);
`endif
        drain();

        // Reset during the 4th bit of a word with one word buffered
        send(8'hF0);
        send(8'h33);
        din_valid = 1'b0;
        wait_valid();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #1 rst_n = 1'b0;
        #1;
        check("midrst_dout_valid",  32'(dout_valid),  32'd0);
        check("midrst_dout_serial", 32'(dout_serial), 32'd0);
        check("midrst_din_ready",   32'(din_ready),   32'd1);
        check("midrst_busy",        32'(busy),        32'd0);
        sent -= 2;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_din_ready", 32'(din_ready), 32'd1);
        send(8'h81);
        drain();

        // Randomized traffic with random idle gaps
        repeat (60) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, DATA_W * 2)));
            send(DATA_W'($urandom));
        end
        drain();

        check("word_count", 32'(words_out), 32'(sent));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
